// File: rtl/col_cim_acc.sv
// col_cim_acc: reduces N_MACRO CIM partial-sum vectors per beat and accumulates cfg_tiles beats per output.
// Define COL_CIM_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise the accumulator wraps.
module col_cim_acc #(
    parameter int unsigned N_MACRO = 4,
    parameter int unsigned N_OUT   = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned ACC_W   = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic [7:0]                  cfg_tiles,
    input  logic                        ps_valid,
    output logic                        ps_ready,
    input  logic [N_MACRO*N_OUT*DW-1:0] ps_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_OUT*ACC_W-1:0]      out_data,
    output logic                        ovf
);
    localparam int unsigned EXT_W = ACC_W - DW;
`ifdef COL_CIM_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

    state_e           state_q, state_d;
    logic [7:0]       tiles_q, tiles_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] s1_sum_q [N_OUT];
    logic [ACC_W-1:0] s1_sum_d [N_OUT];
    logic [ACC_W-1:0] acc_q [N_OUT];
    logic [ACC_W-1:0] acc_d [N_OUT];
    logic [ACC_W-1:0] sum_c [N_OUT];
    logic [DW-1:0]    lane_c;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             ps_ready_c, accept_c, start_c;
    logic [7:0]       tiles_eff_c;
`ifdef COL_CIM_SAT_EN
    logic [ACC_W:0]   ext_c;
    logic             clip_c;
`endif

    // Per-lane sign-extended reduction across all macros
    always_comb begin
        lane_c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            sum_c[j] = '0;
            for (int m = 0; m < N_MACRO; m++) begin
                lane_c   = ps_data[(m*N_OUT+j)*DW +: DW];
                sum_c[j] = sum_c[j] + {{EXT_W{lane_c[DW-1]}}, lane_c};
            end
        end
    end

    // Ready reopens in HOLD only alongside the output handshake so a new vector can start that cycle
    always_comb begin
        ps_ready_c = 1'b0;
        case (state_q)
            IDLE:    ps_ready_c = 1'b1;
            ACC:     ps_ready_c = (cnt_q != tiles_q);
            HOLD:    ps_ready_c = out_ready;
            default: ps_ready_c = 1'b0;
        endcase
        ps_ready_c = ps_ready_c & rdy_en_q;
    end

    assign accept_c    = ps_valid & ps_ready_c & ~clr;
    assign start_c     = accept_c & (state_q != ACC);
    assign tiles_eff_c = (cfg_tiles == 8'd0) ? 8'd1 : cfg_tiles;

    always_comb begin
        state_d     = state_q;
        tiles_d     = tiles_q;
        cnt_d       = cnt_q;
        s1_vld_d    = accept_c;
        s1_first_d  = 1'b0;
        s1_last_d   = 1'b0;
        s1_sum_d    = s1_sum_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
`ifdef COL_CIM_SAT_EN
        ext_c       = '0;
        clip_c      = 1'b0;
`endif
        if (accept_c) begin
            s1_sum_d = sum_c;
        end

        case (state_q)
            ACC: begin
                if (accept_c) begin
                    cnt_d     = cnt_q + 8'd1;
                    s1_last_d = ((cnt_q + 8'd1) == tiles_q);
                end
                if (s1_vld_q && s1_last_q) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                    ovf_d       = 1'b0;
                end
            end
            default: ;
        endcase

        if (start_c) begin
            state_d    = ACC;
            tiles_d    = tiles_eff_c;
            cnt_d      = 8'd1;
            s1_first_d = 1'b1;
            s1_last_d  = (tiles_eff_c == 8'd1);
        end

        // Stage 2: first beat of a vector loads, later beats accumulate
        if (s1_vld_q) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (s1_first_q) begin
                    acc_d[j] = s1_sum_q[j];
                end else begin
`ifdef COL_CIM_SAT_EN
                    ext_c = {acc_q[j][ACC_W-1], acc_q[j]} + {s1_sum_q[j][ACC_W-1], s1_sum_q[j]};
                    if (ext_c[ACC_W] != ext_c[ACC_W-1]) begin
                        clip_c   = 1'b1;
                        acc_d[j] = ext_c[ACC_W] ? ACC_MIN : ACC_MAX;
                    end else begin
                        acc_d[j] = ext_c[ACC_W-1:0];
                    end
`else
                    acc_d[j] = acc_q[j] + s1_sum_q[j];
`endif
                end
            end
`ifdef COL_CIM_SAT_EN
            ovf_d = (s1_first_q ? 1'b0 : ovf_q) | clip_c;
`endif
        end

        if (clr) begin
            state_d     = IDLE;
            tiles_d     = 8'd0;
            cnt_d       = 8'd0;
            s1_vld_d    = 1'b0;
            s1_first_d  = 1'b0;
            s1_last_d   = 1'b0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                s1_sum_d[j] = '0;
                acc_d[j]    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tiles_q     <= 8'd0;
            cnt_q       <= 8'd0;
            rdy_en_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                s1_sum_q[j] <= '0;
                acc_q[j]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            tiles_q     <= tiles_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
            s1_vld_q    <= s1_vld_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            for (int j = 0; j < N_OUT; j++) begin
                s1_sum_q[j] <= s1_sum_d[j];
                acc_q[j]    <= acc_d[j];
            end
        end
    end

    assign ps_ready  = ps_ready_c;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N_OUT; j++) begin
            out_data[j*ACC_W +: ACC_W] = acc_q[j];
        end
    end

endmodule

// File: tb/tb_col_cim_acc.sv
// Directed bench for col_cim_acc: a 20-bit and a 12-bit accumulator instance driven in lockstep.
module tb_col_cim_acc;
    localparam int unsigned N_MACRO = 4;
    localparam int unsigned N_OUT   = 8;
    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 20;
    localparam int unsigned AW12    = 12;
    localparam int unsigned PS_W    = N_MACRO*N_OUT*DW;

    logic                 clk = 1'b0;
    logic                 rst, clr, ps_valid, out_ready;
    logic [7:0]           cfg_tiles;
    logic [PS_W-1:0]      ps_data;
    logic                 ps_ready, out_valid, ovf;
    logic                 ps_ready12, out_valid12, ovf12;
    logic [N_OUT*AW-1:0]  out_data;
    logic [N_OUT*AW12-1:0] out_data12;
    int                   errors = 0;
    int                   checks = 0;

    always #5 clk = ~clk;

    col_cim_acc #(.N_MACRO(N_MACRO), .N_OUT(N_OUT), .DW(DW), .ACC_W(AW)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .cfg_tiles(cfg_tiles),
        .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
    );

    col_cim_acc #(.N_MACRO(N_MACRO), .N_OUT(N_OUT), .DW(DW), .ACC_W(AW12)) u_dut12 (
        .clk(clk), .rst(rst), .clr(clr), .cfg_tiles(cfg_tiles),
        .ps_valid(ps_valid), .ps_ready(ps_ready12), .ps_data(ps_data),
        .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12), .ovf(ovf12)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input int exp20, input int exp12);
        for (int j = 0; j < N_OUT; j++) begin
            chk({tag, "_w20"}, $signed(out_data[j*AW +: AW]), exp20);
            chk({tag, "_w12"}, $signed(out_data12[j*AW12 +: AW12]), exp12);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < int'(N_MACRO*N_OUT); i++) ps_data[i*DW +: DW] = v;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int exp12_sat;
        int ovf12_exp;
`ifdef COL_CIM_SAT_EN
        exp12_sat = 2047;
        ovf12_exp = 1;
`else
        exp12_sat = -1556;
        ovf12_exp = 0;
`endif
        rst = 1'b1; clr = 1'b0; ps_valid = 1'b0; out_ready = 1'b0;
        cfg_tiles = 8'd0; ps_data = '0;
        #2;
        chk("rst_ps_ready", ps_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk_lanes("rst_data", 0, 0);
        #10 rst = 1'b0;
        #1;
        chk("ready_before_edge", ps_ready, 0);
        tick();
        chk("ready_after_edge", ps_ready, 1);

        // One tile, macro m lanes = m+1
        cfg_tiles = 8'd1;
        for (int m = 0; m < int'(N_MACRO); m++)
            for (int j = 0; j < int'(N_OUT); j++)
                ps_data[(m*N_OUT+j)*DW +: DW] = 8'(m + 1);
        ps_valid = 1'b1;
        chk("t1_ready", ps_ready, 1);
        tick();
        ps_valid = 1'b0;
        chk("t1_valid_plus1", out_valid, 0);
        chk("t1_ready_low", ps_ready, 0);
        tick();
        chk("t1_valid_plus2", out_valid, 1);
        chk("t1_ovf", ovf, 0);
        chk_lanes("t1_data", 10, 10);
        out_ready = 1'b1;
        #1;
        chk("t1_ready_handshake", ps_ready, 1);
        tick();
        out_ready = 1'b0;
        chk("t1_valid_drop", out_valid, 0);

        // Three back-to-back beats of -128
        cfg_tiles = 8'd3;
        set_all(8'h80);
        ps_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t2_ready_beat", ps_ready, 1);
            tick();
        end
        ps_valid = 1'b0;
        chk("t2_ready_low", ps_ready, 0);
        chk("t2_valid_plus1", out_valid, 0);
        tick();
        chk("t2_valid_plus2", out_valid, 1);
        chk_lanes("t2_data", -1536, -1536);

        // Back-pressure: hold for 5 cycles
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", ps_ready, 0);
            chk_lanes("hold_data", -1536, -1536);
            tick();
        end
        // New beat with cfg_tiles=0 accepted in the handshake cycle
        cfg_tiles = 8'd0;
        set_all(8'd1);
        ps_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("hs_ready", ps_ready, 1);
        tick();
        ps_valid = 1'b0;
        out_ready = 1'b0;
        chk("t0_valid_plus1", out_valid, 0);
        chk("t0_ready_low", ps_ready, 0);
        tick();
        chk("t0_valid_plus2", out_valid, 1);
        chk_lanes("t0_data", 4, 4);
        do_handshake();

        // Five beats of 127: overflows the 12-bit accumulator
        cfg_tiles = 8'd5;
        set_all(8'd127);
        ps_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        ps_valid = 1'b0;
        chk("t3_valid_plus1", out_valid, 0);
        tick();
        chk("t3_valid", out_valid, 1);
        chk("t3_valid12", out_valid12, 1);
        chk_lanes("t3_data", 2540, exp12_sat);
        chk("t3_ovf20", ovf, 0);
        chk("t3_ovf12", ovf12, ovf12_exp);
        do_handshake();

        // clr after 2 of 4 beats, with a beat offered during clr
        cfg_tiles = 8'd4;
        set_all(8'd1);
        ps_valid = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ps_valid = 1'b0;
        chk("clr_ready", ps_ready, 1);
        chk_lanes("clr_data", 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("clr_no_valid", out_valid, 0);
            tick();
        end
        cfg_tiles = 8'd2;
        set_all(8'd2);
        ps_valid = 1'b1;
        tick();
        tick();
        ps_valid = 1'b0;
        chk("clr_next_plus1", out_valid, 0);
        tick();
        chk("clr_next_valid", out_valid, 1);
        chk_lanes("clr_next_data", 16, 16);
        do_handshake();

        // Async reset after 2 of 4 beats
        cfg_tiles = 8'd4;
        set_all(8'd1);
        ps_valid = 1'b1;
        tick();
        tick();
        ps_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", ps_ready, 0);
        chk_lanes("mrst_data", 0, 0);
        #2 rst = 1'b0;
        tick();
        chk("mrst_ready_back", ps_ready, 1);
        for (int k = 0; k < 3; k++) begin
            chk("mrst_no_valid", out_valid, 0);
            tick();
        end
        cfg_tiles = 8'd2;
        set_all(8'd3);
        ps_valid = 1'b1;
        tick();
        tick();
        ps_valid = 1'b0;
        tick();
        chk("mrst_next_valid", out_valid, 1);
        chk_lanes("mrst_next_data", 24, 24);
        do_handshake();
        chk("final_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
